// File: rtl/obi_stall_pkg.sv
// rtl/obi_stall_pkg.sv - shared types and LFSR helper for the OBI stall controller
package obi_stall_pkg;

  typedef enum logic [1:0] {
    STALL_OFF    = 2'd0,
    STALL_FIXED  = 2'd1,
    STALL_RANDOM = 2'd2,
    STALL_ALT    = 2'd3
  } stall_mode_e;

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_STALL = 2'd1,
    GNT_OPEN  = 2'd2
  } gnt_state_e;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  // Right-shifting Galois step; taps at 16,14,13,11
  function automatic logic [15:0] next_lfsr(input logic [15:0] cur);
    next_lfsr = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/obi_stall_channel.sv
// rtl/obi_stall_channel.sv - one OBI channel: grant stall FSM, LFSR, outstanding count, response FIFO
module obi_stall_channel
  import obi_stall_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_stall_i,
  input  logic [1:0]        mode_i,
  input  logic [CNT_W-1:0]  gnt_stall_i,
  input  logic [CNT_W-1:0]  rvalid_stall_i,
  input  logic [CNT_W-1:0]  max_stall_i,
  input  logic              req_core_i,
  output logic              grant_core_o,
  output logic              req_mem_o,
  input  logic              grant_mem_i,
  input  logic              rvalid_mem_i,
  input  logic [DATA_W-1:0] rdata_mem_i,
  output logic              rvalid_core_o,
  output logic [DATA_W-1:0] rdata_core_o
);

  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  logic [15:0]       lfsr_q;
  gnt_state_e        gnt_state_q;
  logic [CNT_W-1:0]  gnt_cnt_q;
  logic              gnt_tog_q;
  logic              rsp_tog_q;
  logic [OW-1:0]     out_q, out_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_q, wr_q;
  logic [OW-1:0]     fill_q, fill_d;
  logic              head_loaded_q;
  logic [CNT_W-1:0]  head_cnt_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  logic [CNT_W-1:0]  gnt_delay, rsp_delay;
  logic              allow, gnt_open, accept;
  logic              fifo_empty, fifo_full, head_valid, pop, bypass, push, fifo_pop;
  logic [DATA_W-1:0] head_data;

  function automatic logic [CNT_W-1:0] pick_delay(
    input logic             en,
    input logic [1:0]       mode,
    input logic [CNT_W-1:0] fixed_val,
    input logic [CNT_W-1:0] max_val,
    input logic [CNT_W-1:0] rnd,
    input logic             tog
  );
    logic [CNT_W:0] modv;
    modv = {1'b0, rnd} % ({1'b0, max_val} + 1'b1);
    pick_delay = '0;
    if (en) begin
      case (mode)
        STALL_FIXED:  pick_delay = fixed_val;
        STALL_RANDOM: pick_delay = CNT_W'(modv);
        STALL_ALT:    pick_delay = tog ? '0 : fixed_val;
        default:      pick_delay = '0;
      endcase
    end
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Grant and response draw from opposite ends of the LFSR so they stay uncorrelated
  assign gnt_delay = pick_delay(en_stall_i, mode_i, gnt_stall_i, max_stall_i,
                                lfsr_q[CNT_W-1:0], gnt_tog_q);
  assign rsp_delay = pick_delay(en_stall_i, mode_i, rvalid_stall_i, max_stall_i,
                                lfsr_q[15 -: CNT_W], rsp_tog_q);

  assign allow = rst_ni & ((gnt_state_q == GNT_OPEN) |
                           ((gnt_state_q == GNT_IDLE) & req_core_i & (gnt_delay == '0)));
  assign gnt_open     = allow & (out_q < DEPTH_C);
  assign grant_core_o = grant_mem_i & gnt_open;
  assign req_mem_o    = req_core_i & gnt_open;
  assign accept       = req_core_i & grant_core_o;

  // An empty FIFO lets the incoming beat act as head so a zero-delay response costs one cycle
  assign fifo_empty = (fill_q == '0);
  assign fifo_full  = (fill_q == DEPTH_C);
  assign head_valid = ~fifo_empty | rvalid_mem_i;
  assign head_data  = fifo_empty ? rdata_mem_i : mem_q[rd_q];
  assign pop        = head_valid & (head_loaded_q ? (head_cnt_q == '0) : (rsp_delay == '0));
  assign bypass     = fifo_empty & pop;
  assign push       = rvalid_mem_i & ~bypass & ~fifo_full;
  assign fifo_pop   = pop & ~fifo_empty;

  always_comb begin
    out_d = out_q;
    if (accept && !pop) begin
      out_d = out_q + 1'b1;
    end else if (!accept && pop && out_q != '0) begin
      out_d = out_q - 1'b1;
    end
    fill_d = fill_q;
    if (push && !fifo_pop) begin
      fill_d = fill_q + 1'b1;
    end else if (!push && fifo_pop) begin
      fill_d = fill_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_state_q <= GNT_IDLE;
      gnt_cnt_q   <= '0;
      gnt_tog_q   <= 1'b0;
    end else begin
      if (accept) begin
        gnt_tog_q <= ~gnt_tog_q;
      end
      case (gnt_state_q)
        GNT_IDLE: begin
          if (req_core_i) begin
            if (gnt_delay == '0) begin
              if (!grant_core_o) begin
                gnt_state_q <= GNT_OPEN;
              end
            end else begin
              gnt_cnt_q   <= gnt_delay - CNT_W'(1);
              gnt_state_q <= (gnt_delay == CNT_W'(1)) ? GNT_OPEN : GNT_STALL;
            end
          end
        end
        GNT_STALL: begin
          if (!req_core_i) begin
            gnt_state_q <= GNT_IDLE;
            gnt_cnt_q   <= '0;
          end else begin
            gnt_cnt_q <= gnt_cnt_q - CNT_W'(1);
            if (gnt_cnt_q <= CNT_W'(1)) begin
              gnt_state_q <= GNT_OPEN;
            end
          end
        end
        GNT_OPEN: begin
          if (!req_core_i) begin
            gnt_state_q <= GNT_IDLE;
            gnt_cnt_q   <= '0;
          end else if (grant_core_o) begin
            gnt_state_q <= GNT_IDLE;
          end
        end
        default: begin
          gnt_state_q <= GNT_IDLE;
          gnt_cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
      out_q  <= '0;
    end else begin
      lfsr_q <= next_lfsr(lfsr_q);
      out_q  <= out_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_q          <= '0;
      wr_q          <= '0;
      fill_q        <= '0;
      head_loaded_q <= 1'b0;
      head_cnt_q    <= '0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      rsp_tog_q     <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= rdata_mem_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (fifo_pop) begin
        rd_q <= ptr_inc(rd_q);
      end
      fill_q   <= fill_d;
      rvalid_q <= pop;
      if (pop) begin
        rdata_q   <= head_data;
        rsp_tog_q <= ~rsp_tog_q;
      end
      // Delay is sampled once when an entry becomes head, then counted down
      if (pop) begin
        head_loaded_q <= 1'b0;
      end else if (head_valid && !head_loaded_q) begin
        head_loaded_q <= 1'b1;
        head_cnt_q    <= rsp_delay - CNT_W'(1);
      end else if (head_loaded_q) begin
        head_cnt_q <= head_cnt_q - CNT_W'(1);
      end
    end
  end

  assign rvalid_core_o = rvalid_q;
  assign rdata_core_o  = rdata_q;

endmodule

// File: rtl/obi_stall_ctrl.sv
// rtl/obi_stall_ctrl.sv - multi-channel OBI grant/rvalid stall injector
module obi_stall_ctrl
  import obi_stall_pkg::*;
#(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_CH-1:0]          req_core_i,
  output logic [N_CH-1:0]          grant_core_o,
  output logic [N_CH-1:0]          req_mem_o,
  input  logic [N_CH-1:0]          grant_mem_i,
  input  logic [N_CH-1:0]          rvalid_mem_i,
  input  logic [N_CH*DATA_W-1:0]   rdata_mem_i,
  output logic [N_CH-1:0]          rvalid_core_o,
  output logic [N_CH*DATA_W-1:0]   rdata_core_o,
  input  logic                     en_stall_i,
  input  logic [2*N_CH-1:0]        stall_mode_i,
  input  logic [CNT_W*N_CH-1:0]    gnt_stall_i,
  input  logic [CNT_W*N_CH-1:0]    rvalid_stall_i,
  input  logic [CNT_W*N_CH-1:0]    max_stall_i
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    obi_stall_channel #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W),
      .DEPTH  (DEPTH),
      .SEED   (SEED ^ 16'(c))
    ) u_ch (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .en_stall_i     (en_stall_i),
      .mode_i         (stall_mode_i[2*c +: 2]),
      .gnt_stall_i    (gnt_stall_i[CNT_W*c +: CNT_W]),
      .rvalid_stall_i (rvalid_stall_i[CNT_W*c +: CNT_W]),
      .max_stall_i    (max_stall_i[CNT_W*c +: CNT_W]),
      .req_core_i     (req_core_i[c]),
      .grant_core_o   (grant_core_o[c]),
      .req_mem_o      (req_mem_o[c]),
      .grant_mem_i    (grant_mem_i[c]),
      .rvalid_mem_i   (rvalid_mem_i[c]),
      .rdata_mem_i    (rdata_mem_i[DATA_W*c +: DATA_W]),
      .rvalid_core_o  (rvalid_core_o[c]),
      .rdata_core_o   (rdata_core_o[DATA_W*c +: DATA_W])
    );
  end

endmodule

// File: tb/tb_obi_stall_ctrl.sv
// tb/tb_obi_stall_ctrl.sv - directed self-checking bench for obi_stall_ctrl
module tb_obi_stall_ctrl;

  localparam int N_CH = 2, DATA_W = 32, CNT_W = 8, DEPTH = 4;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [N_CH-1:0]        req_core_i, grant_core_o, req_mem_o, grant_mem_i;
  logic [N_CH-1:0]        rvalid_mem_i, rvalid_core_o;
  logic [N_CH*DATA_W-1:0] rdata_mem_i, rdata_core_o;
  logic                   en_stall_i;
  logic [2*N_CH-1:0]      stall_mode_i;
  logic [CNT_W*N_CH-1:0]  gnt_stall_i, rvalid_stall_i, max_stall_i;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        req;
    logic        gmem;
    logic        rvm;
    logic [31:0] rdata;
    logic        e_gnt;
    logic        e_rmem;
    logic        e_rv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [8];
  int   trace [2][1000];

  always #5 clk_i = ~clk_i;

  obi_stall_ctrl #(
    .N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .SEED(16'hACE1)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_core_i     (req_core_i),
    .grant_core_o   (grant_core_o),
    .req_mem_o      (req_mem_o),
    .grant_mem_i    (grant_mem_i),
    .rvalid_mem_i   (rvalid_mem_i),
    .rdata_mem_i    (rdata_mem_i),
    .rvalid_core_o  (rvalid_core_o),
    .rdata_core_o   (rdata_core_o),
    .en_stall_i     (en_stall_i),
    .stall_mode_i   (stall_mode_i),
    .gnt_stall_i    (gnt_stall_i),
    .rvalid_stall_i (rvalid_stall_i),
    .max_stall_i    (max_stall_i)
  );

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req_core_i     = '0;
    grant_mem_i    = '0;
    rvalid_mem_i   = '0;
    rdata_mem_i    = '0;
    en_stall_i     = 1'b0;
    stall_mode_i   = '0;
    gnt_stall_i    = '0;
    rvalid_stall_i = '0;
    max_stall_i    = '0;
    rst_ni         = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 8; i++) begin
      req_core_i[0]      = tbl[i].req;
      grant_mem_i[0]     = tbl[i].gmem;
      rvalid_mem_i[0]    = tbl[i].rvm;
      rdata_mem_i[31:0]  = tbl[i].rdata;
      settle();
      chk($sformatf("%s%0d_gnt", tag, i),    grant_core_o[0],    tbl[i].e_gnt);
      chk($sformatf("%s%0d_reqmem", tag, i), req_mem_o[0],       tbl[i].e_rmem);
      chk($sformatf("%s%0d_rv", tag, i),     rvalid_core_o[0],   tbl[i].e_rv);
      chk($sformatf("%s%0d_rdata", tag, i),  rdata_core_o[31:0], tbl[i].e_rdata);
      step();
    end
    req_core_i   = '0;
    grant_mem_i  = '0;
    rvalid_mem_i = '0;
  endtask

  // One full ch0 transaction: returns cycles from req rise to grant, then retires the response
  task automatic measure(output int d);
    bit got;
    d = -1;
    req_core_i[0] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      settle();
      if (grant_core_o[0]) begin
        d = k;
        break;
      end
      step();
    end
    chk("gnt_wait", (d >= 0), 1);
    step();
    req_core_i[0]     = 1'b0;
    rvalid_mem_i[0]   = 1'b1;
    rdata_mem_i[31:0] = $urandom;
    step();
    rvalid_mem_i[0] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      settle();
      if (rvalid_core_o[0]) begin
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) chk("rsp_wait", got, 1);
    step();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int d;
    int bad;
    int cnt;
    logic [5:0] seen;
    int exp_alt [4];

    //            req  gmem rvm  rdata          gnt  rmem rv   rdata_out
    tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h12345678};

    // Reset state
    do_reset();
    settle();
    chk("rst_gnt",    grant_core_o,  0);
    chk("rst_reqmem", req_mem_o,     0);
    chk("rst_rv",     rvalid_core_o, 0);
    chk("rst_rdata",  rdata_core_o,  0);

    // OFF mode pass-through
    do_reset();
    en_stall_i = 1'b1;
    run_table("off");

    // FIXED programmed but globally disabled behaves like OFF
    do_reset();
    en_stall_i          = 1'b0;
    stall_mode_i        = 4'b0001;
    gnt_stall_i[7:0]    = 8'd3;
    rvalid_stall_i[7:0] = 8'd2;
    run_table("dis");

    // FIXED: grant 3 cycles after req rise, rvalid 3 cycles after memory response
    do_reset();
    en_stall_i          = 1'b1;
    stall_mode_i        = 4'b0001;
    gnt_stall_i[7:0]    = 8'd3;
    rvalid_stall_i[7:0] = 8'd2;
    grant_mem_i         = 2'b11;
    req_core_i[0]       = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("fix_gnt_c%0d", k), grant_core_o[0], (k == 3));
      step();
    end
    req_core_i[0]     = 1'b0;
    rvalid_mem_i[0]   = 1'b1;
    rdata_mem_i[31:0] = 32'hA5A50001;
    settle();
    chk("fix_rv_c0", rvalid_core_o[0], 0);
    step();
    rvalid_mem_i[0] = 1'b0;
    for (int k = 1; k < 4; k++) begin
      settle();
      chk($sformatf("fix_rv_c%0d", k), rvalid_core_o[0], (k == 3));
      step();
    end
    settle();
    chk("fix_rdata", rdata_core_o[31:0], 32'hA5A50001);

    // Outstanding limit: four grants then blocked until a response retires
    do_reset();
    en_stall_i    = 1'b1;
    grant_mem_i   = 2'b11;
    req_core_i[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk($sformatf("dep_gnt_c%0d", k),    grant_core_o[0], (k < 4));
      chk($sformatf("dep_reqmem_c%0d", k), req_mem_o[0],    (k < 4));
      step();
    end
    rvalid_mem_i[0] = 1'b1;
    settle();
    chk("dep_gnt_c6", grant_core_o[0], 0);
    step();
    rvalid_mem_i[0] = 1'b0;
    settle();
    chk("dep_rv_c7",  rvalid_core_o[0], 1);
    chk("dep_gnt_c7", grant_core_o[0],  1);
    step();
    req_core_i = '0;

    // RANDOM: range, coverage and reproducibility
    for (int r = 0; r < 2; r++) begin
      do_reset();
      en_stall_i       = 1'b1;
      stall_mode_i     = 4'b0010;
      max_stall_i[7:0] = 8'd5;
      grant_mem_i      = 2'b11;
      for (int i = 0; i < 1000; i++) begin
        measure(d);
        trace[r][i] = d;
      end
    end
    bad  = 0;
    cnt  = 0;
    seen = '0;
    for (int i = 0; i < 1000; i++) begin
      if (trace[0][i] < 0 || trace[0][i] > 5) bad++;
      else seen[trace[0][i]] = 1'b1;
      if (trace[0][i] != trace[1][i]) cnt++;
    end
    chk("rand_range", bad,  0);
    chk("rand_cover", seen, 6'h3f);
    chk("rand_repro", cnt,  0);

    // ALTERNATE on ch0 with ch1 left OFF
    do_reset();
    en_stall_i       = 1'b1;
    stall_mode_i     = 4'b0011;
    gnt_stall_i      = 16'h0004;
    grant_mem_i      = 2'b11;
    exp_alt          = '{4, 0, 4, 0};
    for (int i = 0; i < 4; i++) begin
      measure(d);
      chk($sformatf("alt_delay%0d", i), d, exp_alt[i]);
    end
    req_core_i = 2'b11;
    settle();
    chk("alt_ch0_stalled", grant_core_o[0], 0);
    chk("alt_ch1_free",    grant_core_o[1], 1);
    step();
    req_core_i[1] = 1'b0;
    for (int k = 1; k < 5; k++) begin
      settle();
      chk($sformatf("alt_gnt_c%0d", k), grant_core_o[0], (k == 4));
      step();
    end
    req_core_i = '0;

    // Reset while ch0 stalls with two responses buffered
    do_reset();
    en_stall_i          = 1'b1;
    stall_mode_i        = 4'b0001;
    gnt_stall_i[7:0]    = 8'd3;
    rvalid_stall_i[7:0] = 8'd50;
    grant_mem_i         = 2'b11;
    req_core_i[1]       = 1'b1;
    step();
    req_core_i[1]      = 1'b0;
    rvalid_mem_i[1]    = 1'b1;
    rdata_mem_i[63:32] = 32'hCAFEF00D;
    step();
    rvalid_mem_i[1] = 1'b0;
    step();
    req_core_i[0] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      settle();
      if (grant_core_o[0]) cnt++;
      step();
    end
    rvalid_mem_i[0]   = 1'b1;
    rdata_mem_i[31:0] = 32'h11111111;
    step();
    rdata_mem_i[31:0] = 32'h22222222;
    step();
    rvalid_mem_i[0] = 1'b0;
    req_core_i[1]   = 1'b1;
    settle();
    chk("rst_pre_grants", cnt, 2);
    chk("rst_pre_gnt1",   grant_core_o[1], 1);
    chk("rst_pre_rdata1", rdata_core_o[63:32], 32'hCAFEF00D);
    rst_ni = 1'b0;
    settle();
    chk("rst_mid_gnt",    grant_core_o,  0);
    chk("rst_mid_reqmem", req_mem_o,     0);
    chk("rst_mid_rv",     rvalid_core_o, 0);
    chk("rst_mid_rdata",  rdata_core_o,  0);
    step();
    step();
    req_core_i = '0;
    rst_ni     = 1'b1;
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      settle();
      if (rvalid_core_o != '0) cnt++;
      step();
    end
    chk("rst_no_stale_rv", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/obi_stall_ctrl.md
# obi_stall_ctrl

Multi-channel OBI perturbation block for the CV32E40X testbench. It sits between the core's OBI ports (instruction and data) and the memory model. Per channel, it inserts configurable stalls on both the grant (address phase) and rvalid (response phase). Randomness comes from a seeded LFSR, so runs are reproducible and synthesizable rather than tied to simulator random calls.

## Interface
Parameters:
- N_CH, 2, number of independent OBI channels
- DATA_W, 32, rdata width per channel
- CNT_W, 8, width of stall counters and delay fields
- DEPTH, 4, response buffer depth per channel; also the maximum number of outstanding transactions
- SEED, 16'hACE1, LFSR seed; channel c uses SEED ^ c (c ≠ 0 guaranteed nonzero)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_core_i  in  N_CH  core request
- grant_core_o  out  N_CH  grant to core
- req_mem_o  out  N_CH  request to memory, gated
- grant_mem_i  in  N_CH  memory grant
- rvalid_mem_i  in  N_CH  memory response valid
- rdata_mem_i  in  N_CH*DATA_W  memory response data
- rvalid_core_o  out  N_CH  response valid to core, one-cycle pulse
- rdata_core_o  out  N_CH*DATA_W  response data to core
- en_stall_i  in  1  global enable; 0 forces every delay to 0
- stall_mode_i  in  2*N_CH  per-channel mode: 0 OFF, 1 FIXED, 2 RANDOM, 3 ALTERNATE
- gnt_stall_i  in  CNT_W*N_CH  FIXED grant delay
- rvalid_stall_i  in  CNT_W*N_CH  FIXED rvalid delay
- max_stall_i  in  CNT_W*N_CH  RANDOM upper bound, inclusive

## Operation
- Delay selection for each channel:
  - OFF: delay 0.
  - FIXED: delay is the programmed value.
  - RANDOM: delay = lfsr mod (max+1), where max = max_stall_i. A max of 0 gives delay 0.
  - ALTERNATE: FIXED delay on odd-numbered requests, 0 on even-numbered requests. A per-channel toggle flips on each accepted grant.
- LFSR: 16-bit Galois, one per channel. It advances every cycle after reset. Grant and rvalid use disjoint bit slices of it.
- gnt_open = allow & (outstanding < DEPTH)
  - grant_core_o = grant_mem_i & gnt_open
  - req_mem_o = req_core_i & gnt_open
- Grant FSM per channel: IDLE, STALL, OPEN.
  - IDLE, req=0: allow=0.
  - IDLE, req=1, delay 0: allow=1 combinationally. If granted, stay in IDLE; otherwise go to OPEN.
  - IDLE, req=1, delay d>0: allow=0, cnt<=d-1, go to STALL.
  - STALL: allow=0. cnt decrements each cycle; when cnt=0, go to OPEN.
  - OPEN: allow=1. On req&grant_core_o, go to IDLE.
  - req dropping in STALL or OPEN (an OBI violation): return to IDLE and clear cnt.
- outstanding counter:
  - +1 on each accepted grant.
  - −1 on each rvalid_core_o.
  - Both in the same cycle: no change.
- Response path per channel:
  - A DEPTH-entry FIFO captures rdata_mem_i on rvalid_mem_i.
  - When an entry becomes head, a delay is sampled and the head counter is loaded with it.
  - When the head counter reaches 0, the head is popped with rvalid_core_o=1 and rdata_core_o=head data (both registered).
  - Push and pop in the same cycle are legal.
  - The FIFO cannot overflow, because outstanding < DEPTH gates grants.

## Timing
- Reset values: grant_core_o=0, req_mem_o=0, rvalid_core_o=0, rdata_core_o=0. FSM in IDLE; counters, FIFO and toggle cleared; LFSR=seed.
- Grant delay d: the earliest grant_core_o is d cycles after the cycle in which req rises. With d=0 it is the same cycle.
- Response latency: minimum 1 cycle from rvalid_mem_i to rvalid_core_o (delay 0). With rvalid delay r, latency is 1+r cycles for the head entry.
- Back-to-back responses with delay 0: one rvalid_core_o per cycle.
- A change to en_stall_i or the configuration mid-stall affects only delays sampled afterwards.
- Asserting reset mid-transaction discards the FIFO contents and the outstanding count immediately.

## Structure
- Package obi_stall_pkg holds:
  - stall_mode_e (OFF/FIXED/RANDOM/ALTERNATE)
  - gnt_state_e
  - LFSR polynomial constant 16'hB400
  - function next_lfsr()
- Sub-module obi_stall_channel: one grant FSM, LFSR, outstanding counter and response FIFO. The top level is a generate loop over N_CH that slices the packed vectors.

## Test plan
- OFF mode, req held with grant_mem_i=1: grant_core_o in the same cycle; rvalid_core_o 1 cycle after rvalid_mem_i, with data 32'hDEADBEEF passed through unchanged.
- FIXED, gnt_stall=3, rvalid_stall=2: grant on the 4th cycle of req (cycle 3 relative to req rise); rvalid_core_o 3 cycles after rvalid_mem_i.
- DEPTH=4, memory withholds rvalid: after 4 grants, req_mem_o and grant_core_o stay 0. When one response is released, a grant is possible again in that same cycle.
- RANDOM, max=5, 1000 requests: every grant delay lies in [0,5] and all six values occur. Two runs with the same SEED give identical traces.
- ALTERNATE, gnt_stall=4: delays follow 4,0,4,0. Channel 1 in OFF mode is unaffected by channel 0 activity.
- Reset mid-STALL with 2 responses buffered: all outputs go to 0 immediately, and no stale rvalid_core_o appears after reset is released.
